// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR sample queue and sequencer.
package fir_pkg;
  typedef enum logic {IDLE, SEQ} seq_state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_TAPS   = 1021;
  localparam int SMPL_W     = 16;
endpackage

// File: rtl/dp_queue_ram.sv
// Simple dual-port sample RAM: write port plus registered, enable-gated read port.
// The read register holds its value while re is low and resets to zero.
module dp_queue_ram #(
  parameter int ADDR_W = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdat,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdat
);
  logic [DW-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdat <= '0;
    else if (re) rdat <= mem[raddr];
  end
endmodule

// File: rtl/fir_queue_seq.sv
// Circular stereo sample queue; each new sample (once TAPS are held) streams the
// TAPS newest samples oldest-first to the FIR banks under the sequencing strobe.
module fir_queue_seq
  import fir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAPS   = DEF_TAPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wrt_smpl,
  input  logic signed [SMPL_W-1:0] lft_smpl,
  input  logic signed [SMPL_W-1:0] rght_smpl,
  output logic                     sequencing,
  output logic signed [SMPL_W-1:0] lft_out,
  output logic signed [SMPL_W-1:0] rght_out,
  output logic                     ovr
);
  localparam logic [ADDR_W-1:0] TAPS_A   = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  seq_state_t          state, state_nxt;
  logic [ADDR_W-1:0]   new_ptr, old_ptr, rd_ptr, cnt;
  logic [ADDR_W-1:0]   occ_nxt;
  logic                full;
  logic                start, done;
  logic [2*SMPL_W-1:0] rd_dat;

  // Occupancy as it will be once the current write lands.
  assign occ_nxt = new_ptr - old_ptr + ONE;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (wrt_smpl && (full || occ_nxt == TAPS_A)) begin
          state_nxt = SEQ;
          start     = 1'b1;
        end
      end
      SEQ: begin
        if (cnt == LAST_CNT) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      old_ptr <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (wrt_smpl) new_ptr <= new_ptr + ONE;
      if (wrt_smpl && occ_nxt == TAPS_A) full <= 1'b1;
      if (wrt_smpl && state == SEQ) ovr <= 1'b1;

      if (start) begin
        rd_ptr <= old_ptr;
        cnt    <= '0;
      end else if (state == SEQ) begin
        rd_ptr <= rd_ptr + ONE;
        cnt    <= cnt + ONE;
      end

      // Oldest sample retires once its last burst has been issued.
      if (done) old_ptr <= old_ptr + ONE;
    end
  end

  assign sequencing = (state == SEQ);

  dp_queue_ram #(
    .ADDR_W (ADDR_W),
    .DW     (2*SMPL_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wrt_smpl),
    .waddr (new_ptr),
    .wdat  ({lft_smpl, rght_smpl}),
    .re    (sequencing),
    .raddr (rd_ptr),
    .rdat  (rd_dat)
  );

  assign lft_out  = rd_dat[2*SMPL_W-1:SMPL_W];
  assign rght_out = rd_dat[SMPL_W-1:0];
endmodule
